ssa_split_sequencer: RTL and testbench
======================================

// Module: ssa_split_sequencer
// PURPOSE
//   Front-end sequencer for the SSA multiplier datapath. Accepts one operand pair
//   (a, b), splits each operand into N = IN_W/PIECE_W pieces, zero-extends each piece
//   to PAD_W bits, and streams 2N points per operand to the transform stage.
//   Points 0..N-1 carry the pieces, least-significant piece first. Points N..2N-1 are
//   zero padding for the cyclic convolution. Output is one point-pair per beat over
//   a valid/ready handshake.
// PARAMETERS
//   IN_W     8   operand width; must be a multiple of PIECE_W
//   PIECE_W  2   bits per split piece
//   PAD_W    12  width of each emitted point; must satisfy PAD_W >= PIECE_W
//   (derived) N = IN_W/PIECE_W (default 4); IDX_W = $clog2(2*N) (default 3)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      sequencer can accept an operand pair
//   in_a       in   IN_W   operand A
//   in_b       in   IN_W   operand B
//   out_valid  out  1      point pair valid
//   out_ready  in   1      transform stage accepts the point pair
//   out_a      out  PAD_W  point k of A
//   out_b      out  PAD_W  point k of B
//   out_idx    out  IDX_W  point index k, from 0 to 2N-1
//   out_last   out  1      high on the beat where k == 2N-1
//   busy       out  1      high while a transaction is in flight
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): state=IDLE. out_valid=0, out_a=0, out_b=0,
//   out_idx=0, out_last=0, busy=0. Both captured operand registers are cleared.
//   Any transaction in flight is dropped with no further beats.
// - States:
//   IDLE   : in_ready=1, out_valid=0.
//            On in_valid&&in_ready: capture in_a and in_b, set idx=0, go to STREAM.
//   STREAM : out_valid=1, busy=1.
//            On out_valid&&out_ready: idx=idx+1.
//            If idx==2N-1 on that handshake: go to IDLE, unless a new pair is accepted
//            in the same cycle (see back-to-back).
// - Point generation, with k = idx:
//   out_a = (k < N) ? {(PAD_W-PIECE_W)'b0, A[k*PIECE_W +: PIECE_W]} : 0.
//   out_b is generated the same way from B.
// - Latency: the first point is valid in the cycle after input acceptance.
//   Data outputs are registered.
// - Backpressure: while out_valid && !out_ready, out_a, out_b, out_idx and out_last
//   hold stable. No beats are skipped or duplicated.
// - Back-to-back:
//   in_ready = (state==IDLE) || (state==STREAM && out_last && out_ready).
//   This is a combinational path from out_ready to in_ready; it is intentional.
//   If a pair is accepted on the last beat, the new pair is captured, idx resets to 0,
//   and state stays STREAM. There is no bubble between transactions.
// - in_valid is ignored in STREAM except on the last handshaking beat.
//   in_a and in_b are sampled only at acceptance.
// - The index counter never wraps past 2N-1; it is reloaded to 0 on acceptance.
// - Elaboration: $error if IN_W % PIECE_W != 0 or if PAD_W < PIECE_W.
// TESTING
// 1. Reset:
//    rst_n low -> out_valid=0, in_ready=1, busy=0, out_idx=0, out_a=out_b=0.
// 2. Basic stream:
//    in_a=8'hB4, in_b=8'h1B, out_ready=1 -> 8 beats, idx 0..7.
//    out_a = 0,1,3,2,0,0,0,0 and out_b = 3,2,1,0,0,0,0,0 (each 12 bits wide).
//    out_last=1 only on idx 7. busy drops the cycle after that beat.
// 3. Backpressure:
//    Same pair; hold out_ready=0 for 3 cycles while idx=2 -> out_idx=2, out_a=3,
//    out_b=1 stay stable. The stream then resumes at idx=3 with no loss.
// 4. Back-to-back:
//    Keep in_valid high with a second pair in_a=8'hFF, in_b=8'h01 -> the pair is
//    accepted on the idx-7 handshake. Next cycle: idx=0, out_a=3, out_b=1, no idle gap.
// 5. Reset mid-stream:
//    Assert rst_n=0 at idx=5 -> outputs clear immediately (out_valid=0, out_idx=0).
//    After release, in_ready=1; a new pair starts at idx=0.
// 6. Ignore while busy:
//    Pulse in_valid at idx=3 with out_ready=1 -> in_ready=0, the operand is not
//    captured, and the stream completes with the original data.

Source files
------------

// File: rtl/ssa_split_sequencer.sv
// Front-end sequencer for the SSA multiplier: splits an operand pair into zero-extended
// pieces and streams 2N points per operand (pieces first, then zero padding).
module ssa_split_sequencer #(
  parameter int IN_W    = 8,
  parameter int PIECE_W = 2,
  parameter int PAD_W   = 12,
  localparam int N      = IN_W / PIECE_W,
  localparam int IDX_W  = $clog2(2 * N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_a,
  input  logic [IN_W-1:0]    in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PAD_W-1:0]   out_a,
  output logic [PAD_W-1:0]   out_b,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);

  if (IN_W % PIECE_W != 0) begin : g_chk_split
    $error("IN_W must be a multiple of PIECE_W");
  end
  if (PAD_W < PIECE_W) begin : g_chk_pad
    $error("PAD_W must be at least PIECE_W");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_reg;
  logic [IN_W-1:0]    a_reg;
  logic [IN_W-1:0]    b_reg;
  logic               accept;
  logic               fire;
  logic [IDX_W-1:0]   idx_next;
  logic [IN_W-1:0]    src_a;
  logic [IN_W-1:0]    src_b;
  logic [PIECE_W-1:0] piece_a [N];
  logic [PIECE_W-1:0] piece_b [N];
  logic [PAD_W-1:0]   point_a_next;
  logic [PAD_W-1:0]   point_b_next;

  // out_ready reaches in_ready combinationally so a new pair can land on the last beat.
  assign in_ready = (state_reg == IDLE) || (state_reg == STREAM && out_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign idx_next = accept ? '0 : out_idx + IDX_W'(1);
  assign src_a    = accept ? in_a : a_reg;
  assign src_b    = accept ? in_b : b_reg;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_piece
    assign piece_a[gi] = src_a[gi*PIECE_W +: PIECE_W];
    assign piece_b[gi] = src_b[gi*PIECE_W +: PIECE_W];
  end

  // Indices N..2N-1 match no piece and fall through to the zero padding.
  always_comb begin
    point_a_next = '0;
    point_b_next = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_next == IDX_W'(i)) begin
        point_a_next = PAD_W'(piece_a[i]);
        point_b_next = PAD_W'(piece_b[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (accept || (fire && !out_last)) begin
      state_reg <= STREAM;
      out_valid <= 1'b1;
      busy      <= 1'b1;
      out_idx   <= idx_next;
      out_a     <= point_a_next;
      out_b     <= point_b_next;
      out_last  <= (idx_next == LAST_IDX);
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
      end
    end else if (fire) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_idx   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssa_split_sequencer.sv
// Bench for ssa_split_sequencer: vector table, hand-written corner sequences and a
// randomized run against a queue-based model of the emitted point stream.
module tb_ssa_split_sequencer;

  localparam int IN_W    = 8;
  localparam int PIECE_W = 2;
  localparam int PAD_W   = 12;
  localparam int N       = IN_W / PIECE_W;
  localparam int IDX_W   = $clog2(2 * N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_a = '0;
  logic [IN_W-1:0]   in_b = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PAD_W-1:0]  out_a;
  logic [PAD_W-1:0]  out_b;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  ssa_split_sequencer #(.IN_W(IN_W), .PIECE_W(PIECE_W), .PAD_W(PAD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Point k of operand x, straight from the splitting rule.
  function automatic int point(input int x, input int k);
    if (k >= N) return 0;
    return (x >> (k * PIECE_W)) % (1 << PIECE_W);
  endfunction

  typedef struct {
    logic             iv;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             ordy;
    logic             ev;
    int               eidx;
    int               ea;
    int               eb;
    logic             elast;
    logic             erdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input int a, input int b, input logic ordy,
                     input logic ev, input int eidx, input int ea, input int eb,
                     input logic elast, input logic erdy);
    vec_t v;
    v.iv = iv; v.a = IN_W'(a); v.b = IN_W'(b); v.ordy = ordy;
    v.ev = ev; v.eidx = eidx; v.ea = ea; v.eb = eb; v.elast = elast; v.erdy = erdy;
    tbl.push_back(v);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int   a;
    int   b;
    int   idx;
    logic last;
  } beat_t;

  beat_t model_q[$];

  initial begin
    // Reset state
    #2;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst busy", 32'(busy), 0);
    check("rst out_idx", 32'(out_idx), 0);
    check("rst out_a", 32'(out_a), 0);
    check("rst out_b", 32'(out_b), 0);
    check("rst out_last", 32'(out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream, backpressure at idx 2, back-to-back pair on the idx-7 beat
    add(1, 'hB4, 'h1B, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 3, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 2, 3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 2, 3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 2, 3, 1, 0, 0);
    add(0, 0, 0, 1, 1, 2, 3, 1, 0, 0);
    add(0, 0, 0, 1, 1, 3, 2, 0, 0, 0);
    add(0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 5, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 6, 0, 0, 0, 0);
    add(1, 'hFF, 'h01, 1, 1, 7, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 1, 1, 1, 3, 0, 0, 0);
    add(0, 0, 0, 1, 1, 2, 3, 0, 0, 0);
    add(0, 0, 0, 1, 1, 3, 3, 0, 0, 0);
    add(0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 5, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 6, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 7, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      in_valid = tbl[i].iv; in_a = tbl[i].a; in_b = tbl[i].b; out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].ev));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
      if (tbl[i].ev) begin
        check($sformatf("vec%0d out_idx", i), 32'(out_idx), tbl[i].eidx);
        check($sformatf("vec%0d out_a", i), 32'(out_a), tbl[i].ea);
        check($sformatf("vec%0d out_b", i), 32'(out_b), tbl[i].eb);
        check($sformatf("vec%0d out_last", i), 32'(out_last), 32'(tbl[i].elast));
      end
    end
    $display("table: %0d vectors replayed", tbl.size());

    // Asynchronous reset in the middle of a stream
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'hB4; in_b = 8'h1B; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst idx before", 32'(out_idx), 5);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst out_idx", 32'(out_idx), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst out_a", 32'(out_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready", 32'(in_ready), 1);
    check("midrst idle", 32'(out_valid), 0);
    in_valid = 1'b1; in_a = 8'h1B; in_b = 8'hB4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midrst restart idx", 32'(out_idx), 0);
    check("midrst restart a", 32'(out_a), 3);
    check("midrst restart b", 32'(out_b), 0);
    $display("midstream reset: new pair a=1b b=b4 started");

    // in_valid pulses while busy must not disturb the stream
    reset_pulse();
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'hB4; in_b = 8'h1B; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy idx0", 32'(out_idx), 0);
    for (int k = 1; k < 2 * N; k++) begin
      @(posedge clk); #1;
      in_valid = (k <= 3); in_a = 8'hFF; in_b = 8'hFF;
      #1;
      check($sformatf("busy k%0d idx", k), 32'(out_idx), k);
      check($sformatf("busy k%0d a", k), 32'(out_a), point('hB4, k));
      check($sformatf("busy k%0d b", k), 32'(out_b), point('h1B, k));
      if (k <= 3) check($sformatf("busy k%0d in_ready", k), 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    check("busy done", 32'(out_valid), 0);
    $display("ignore-while-busy: stream b4/1b completed");

    // Randomized traffic against the queue model
    reset_pulse();
    model_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic m_acc;
      logic m_fire;
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = IN_W'($urandom);
      in_b      = IN_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (model_q.size() == 0) begin
        check("rnd out_valid", 32'(out_valid), 0);
        check("rnd busy", 32'(busy), 0);
        check("rnd in_ready", 32'(in_ready), 1);
      end else begin
        check("rnd out_valid", 32'(out_valid), 1);
        check("rnd busy", 32'(busy), 1);
        check("rnd out_idx", 32'(out_idx), model_q[0].idx);
        check("rnd out_a", 32'(out_a), model_q[0].a);
        check("rnd out_b", 32'(out_b), model_q[0].b);
        check("rnd out_last", 32'(out_last), 32'(model_q[0].last));
        check("rnd in_ready", 32'(in_ready), 32'(out_ready && model_q[0].last));
      end
      m_fire = (model_q.size() != 0) && out_ready;
      m_acc  = in_valid && ((model_q.size() == 0) || (model_q[0].last && out_ready));
      if (m_fire) void'(model_q.pop_front());
      if (m_acc) begin
        for (int k = 0; k < 2 * N; k++) begin
          beat_t bt;
          bt.a = point(int'(in_a), k);
          bt.b = point(int'(in_b), k);
          bt.idx = k;
          bt.last = (k == 2 * N - 1);
          model_q.push_back(bt);
        end
        $display("rnd cycle %0d: accepted a=%02h b=%02h", cyc, in_a, in_b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
